sh7034_dmac_arb: RTL



---
 rtl/sh7034_dmac_arb_if.sv | 29 ++
 rtl/sh7034_dmac_arb.sv | 101 ++++++++++
 2 files changed

// File: rtl/sh7034_dmac_arb_if.sv
// Request/grant bundle between the DMAC channel request latches, the
// channel arbiter and the SAR/DAR/TCR transfer engine.
interface sh7034_dmac_arb_if;
   logic       CE;
   logic       PR;
   logic [3:0] CH_REQ;
   logic [3:0] CH_EN;
   logic [3:0] CH_BURST;
   logic       ABORT;
   logic       XFER_DONE;
   logic       CH_END;
   logic       GNT_VLD;
   logic [1:0] GNT_CH;
   logic [3:0] GNT_OH;
   logic       BUS_HOLD;
   logic [1:0] RR_LAST;

   // Side that raises requests and consumes the grant.
   modport master (
      output CE, PR, CH_REQ, CH_EN, CH_BURST, ABORT, XFER_DONE, CH_END,
      input  GNT_VLD, GNT_CH, GNT_OH, BUS_HOLD, RR_LAST
   );

   // The arbiter itself.
   modport slave (
      input  CE, PR, CH_REQ, CH_EN, CH_BURST, ABORT, XFER_DONE, CH_END,
      output GNT_VLD, GNT_CH, GNT_OH, BUS_HOLD, RR_LAST
   );
endinterface

// File: rtl/sh7034_dmac_arb.sv
// SH7034 DMAC channel arbiter/sequencer. Picks the channel that owns the
// transfer engine for the next unit, in fixed (0>1>2>3) or round-robin
// order, and holds the grant across units while a burst-mode owner keeps
// requesting. Cycle-steal owners always give the bus back after a unit.
module sh7034_dmac_arb #(
   parameter logic [1:0] RR_RESET_LAST = 2'd3
) (
   input logic              CLK,
   input logic              RST_N,
   sh7034_dmac_arb_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic       gnt_vld;
   logic [1:0] gnt_ch;
   logic [3:0] gnt_oh;
   logic       bus_hold;
   logic [1:0] rr_last;

   logic [3:0] ereq;
   logic [1:0] fixed_win;
   logic [1:0] rr_win;
   logic [1:0] winner;
   logic [1:0] idx;

   // Effective requests and the winners under both priority schemes.
   always_comb begin
      ereq      = bus.CH_REQ & bus.CH_EN;
      fixed_win = 2'd0;
      rr_win    = 2'd0;
      idx       = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (ereq[i]) fixed_win = 2'(i);
      end
      // Scan from farthest to nearest so the nearest requester after
      // the last-served channel is the one that sticks.
      for (int off = 4; off >= 1; off--) begin
         idx = rr_last + 2'(off);
         if (ereq[idx]) rr_win = idx;
      end
      winner = bus.PR ? rr_win : fixed_win;
   end

   // Grant FSM: arbitrate in IDLE, hold the owner in GRANT until its unit
   // completes, keep it only for a still-requesting burst owner.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         gnt_vld  <= 1'b0;
         gnt_ch   <= 2'd0;
         gnt_oh   <= 4'd0;
         bus_hold <= 1'b0;
         rr_last  <= RR_RESET_LAST;
      end else if (bus.CE) begin
         if (bus.ABORT) begin
            state    <= IDLE;
            gnt_vld  <= 1'b0;
            gnt_oh   <= 4'd0;
            bus_hold <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ereq != 4'd0) begin
                     state    <= GRANT;
                     gnt_vld  <= 1'b1;
                     gnt_ch   <= winner;
                     gnt_oh   <= 4'd1 << winner;
                     bus_hold <= bus.CH_BURST[winner];
                  end
               end
               GRANT: begin
                  if (bus.XFER_DONE) begin
                     rr_last <= gnt_ch;
                     if (bus.CH_END || !(bus_hold && ereq[gnt_ch])) begin
                        state    <= IDLE;
                        gnt_vld  <= 1'b0;
                        gnt_oh   <= 4'd0;
                        bus_hold <= 1'b0;
                     end
                  end
               end
               default: begin
                  state    <= IDLE;
                  gnt_vld  <= 1'b0;
                  gnt_oh   <= 4'd0;
                  bus_hold <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.GNT_VLD  = gnt_vld;
   assign bus.GNT_CH   = gnt_ch;
   assign bus.GNT_OH   = gnt_oh;
   assign bus.BUS_HOLD = bus_hold;
   assign bus.RR_LAST  = rr_last;

endmodule
